cdc_hs_rx: RTL and testbench

CDC_HS_RX -- requirements
Module: cdc_hs_rx

---
 rtl/cdc_hs_rx.sv | 118 +++++++++++
 tb/tb_cdc_hs_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_rx.sv
// Receive side of a four-phase req/ack clock-domain-crossing handshake.
// req_sync has already passed through a synchronizer into clk. Each request
// pulse captures one data word, which is presented to a valid/ready consumer.
// ack is raised once the consumer takes the word. ack falls after the sender
// drops req. A stuck-high req in ACK and a req drop before the word is taken
// both raise a sticky err.
module cdc_hs_rx #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64   // legal 2..65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_sync,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err,
  input  logic             err_clr,
  output logic [15:0]      xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  // The counter stops at TO_LAST. err is raised on the step from TO_ARM to
  // TO_LAST, so it becomes visible on the TIMEOUT-th ACK cycle. Because the
  // raise happens only on that step, err_clr still works while the counter
  // sits saturated.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] TO_ARM  = 16'(TIMEOUT - 2);

  state_t      state;
  logic [15:0] to_cnt;
  logic        handshake;
  logic        err_set;

  assign handshake = out_valid && out_ready;

  // Error sources: req dropped before the word was taken, or the ACK timeout
  // being reached while req is still high.
  // NOTE: always_comb assigns err_set on every path (here as a single
  // expression), so no latch can be inferred.
  always_comb begin
    err_set = ((state == VALID) && !req_sync) ||
              ((state == ACK) && req_sync && (to_cnt == TO_ARM));
  end

  // Handshake FSM. All outputs are registered alongside the state.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // updates from values sampled at the same edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ack       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      out_data  <= '0;
      xfer_cnt  <= '0;
      to_cnt    <= '0;
    end else begin
      // set wins over clear
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req_sync) begin
            out_data  <= data_in;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= VALID;
          end
        end

        VALID: begin
          // out_data is frozen here; data_in is ignored until the next capture
          if (handshake) begin
            out_valid <= 1'b0;
            ack       <= 1'b1;
            to_cnt    <= '0;
            xfer_cnt  <= xfer_cnt + 16'd1;
            state     <= ACK;
          end
        end

        ACK: begin
          // IDLE is re-entered only after req is seen low, so one req pulse
          // yields exactly one word
          if (!req_sync) begin
            ack   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 16'd1;
          end
        end

        default: begin
          ack       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Directed bench for cdc_hs_rx (WIDTH=8, TIMEOUT=4). Expected words are queued
// when a request is driven and popped when the DUT presents out_valid.
module tb_cdc_hs_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_sync;
  logic [7:0]  data_in;
  logic        ack;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        err;
  logic        err_clr;
  logic [15:0] xfer_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  sb[$];
  logic [15:0] exp_cnt = 16'd0;

  cdc_hs_rx #(.WIDTH(8), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_sync  (req_sync),
    .data_in   (data_in),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      check(tag, 32'(out_data), 32'(sb.pop_front()));
    end
  endtask

  // Fast full handshake: capture, accept, and drop req.
  task automatic do_xfer(input logic [7:0] d, input string tag);
    data_in   = d;
    req_sync  = 1'b1;
    out_ready = 1'b1;
    sb.push_back(d);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    pop_check({tag, "_data"});
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check({tag, "_cnt"}, 32'(xfer_cnt), 32'(exp_cnt));
    req_sync = 1'b0;
    tick();
    check({tag, "_ack_low"}, 32'(ack), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_sync  = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    check("rst_ack",   32'(ack),       32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_cnt",   32'(xfer_cnt),  32'd0);

    // basic transfer
    data_in   = 8'hA5;
    req_sync  = 1'b1;
    out_ready = 1'b1;
    sb.push_back(8'hA5);
    tick();
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_busy",  32'(busy),      32'd1);
    check("basic_ack0",  32'(ack),       32'd0);
    pop_check("basic_data");
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check("basic_ack1",   32'(ack),       32'd1);
    check("basic_valid0", 32'(out_valid), 32'd0);
    check("basic_cnt",    32'(xfer_cnt),  32'(exp_cnt));
    req_sync = 1'b0;
    tick();
    check("basic_ack_low", 32'(ack),  32'd0);
    check("basic_idle",    32'(busy), 32'd0);
    check("basic_err",     32'(err),  32'd0);

    // backpressure: data_in changes while the word is held
    data_in   = 8'hA5;
    req_sync  = 1'b1;
    out_ready = 1'b0;
    sb.push_back(8'hA5);
    tick();
    data_in = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  32'(out_data),  32'hA5);
      check("bp_ack",   32'(ack),       32'd0);
    end
    pop_check("bp_pop");
    out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check("bp_ack1", 32'(ack),      32'd1);
    check("bp_cnt",  32'(xfer_cnt), 32'(exp_cnt));
    req_sync = 1'b0;
    tick();
    check("bp_ack_low", 32'(ack), 32'd0);

    // timeout: req held high in ACK, err appears on the 4th ACK cycle
    data_in  = 8'h5A;
    req_sync = 1'b1;
    sb.push_back(8'h5A);
    tick();
    pop_check("to_data");
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_cnt = (k == 1) ? exp_cnt + 16'd1 : exp_cnt;
      check("to_ack", 32'(ack), 32'd1);
      check("to_err", 32'(err), (k == 4) ? 32'd1 : 32'd0);
    end
    check("to_no_recapture", 32'(out_valid), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_clr",     32'(err), 32'd0);
    check("to_hold_ack", 32'(ack), 32'd1);
    tick();
    check("to_sat_err", 32'(err),  32'd0);
    check("to_sat_busy", 32'(busy), 32'd1);
    req_sync = 1'b0;
    tick();
    check("to_ack_low", 32'(ack),  32'd0);
    check("to_idle",    32'(busy), 32'd0);
    check("to_cnt",     32'(xfer_cnt), 32'(exp_cnt));

    // err_clr in the same cycle as the timeout condition: set wins
    data_in  = 8'h96;
    req_sync = 1'b1;
    sb.push_back(8'h96);
    tick();
    pop_check("sim_data");
    tick();
    exp_cnt = exp_cnt + 16'd1;
    tick();
    tick();
    check("sim_err_pre", 32'(err), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("sim_set_wins", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("sim_clr", 32'(err), 32'd0);
    req_sync = 1'b0;
    tick();
    check("sim_idle", 32'(busy), 32'd0);

    // premature req drop in VALID
    data_in   = 8'hC3;
    req_sync  = 1'b1;
    out_ready = 1'b0;
    sb.push_back(8'hC3);
    tick();
    req_sync = 1'b0;
    tick();
    check("pd_err",   32'(err),       32'd1);
    check("pd_valid", 32'(out_valid), 32'd1);
    pop_check("pd_data");
    out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check("pd_ack1", 32'(ack),      32'd1);
    check("pd_cnt",  32'(xfer_cnt), 32'(exp_cnt));
    tick();
    check("pd_ack0", 32'(ack),  32'd0);
    check("pd_idle", 32'(busy), 32'd0);

    // IDLE with req low: out_data holds the last word
    data_in = 8'h11;
    tick();
    tick();
    check("idle_hold_data",  32'(out_data),  32'hC3);
    check("idle_hold_valid", 32'(out_valid), 32'd0);

    // reset during VALID abandons the word
    data_in   = 8'h77;
    req_sync  = 1'b1;
    out_ready = 1'b0;
    tick();
    check("rv_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rv_valid0", 32'(out_valid), 32'd0);
    check("rv_ack0",   32'(ack),       32'd0);
    check("rv_busy0",  32'(busy),      32'd0);
    check("rv_err0",   32'(err),       32'd0);
    check("rv_data0",  32'(out_data),  32'd0);
    check("rv_cnt0",   32'(xfer_cnt),  32'd0);
    sb.delete();
    exp_cnt = 16'd0;
    data_in = 8'h88;
    sb.push_back(8'h88);
    rst_n = 1'b1;
    tick();
    check("rv_new_valid", 32'(out_valid), 32'd1);
    pop_check("rv_new_data");
    out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check("rv_new_ack", 32'(ack),      32'd1);
    check("rv_new_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    req_sync = 1'b0;
    tick();
    check("rv_new_idle", 32'(busy), 32'd0);

    // xfer_cnt wrap: preload near the top instead of 65536 real transfers
    force dut.xfer_cnt = 16'hFFFE;
    #1;
    release dut.xfer_cnt;
    exp_cnt = 16'hFFFE;
    do_xfer(8'h01, "wrap_a");
    do_xfer(8'h02, "wrap_b");
    check("wrap_zero", 32'(xfer_cnt), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
